// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: register-file and data widths plus the load-type
// encodings that EX, ID and MEM all agree on.
package mem_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic [2:0] {
    LD_OP_W  = 3'b000,
    LD_OP_B  = 3'b001,
    LD_OP_H  = 3'b010,
    LD_OP_BU = 3'b011,
    LD_OP_HU = 3'b100
  } ld_op_e;

  // Everything MEM latches from EX when it accepts an instruction.
  typedef struct packed {
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    alu_result;
    logic                 res_from_mem;
    logic [2:0]           ld_op;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_waddr;
  } ms_payload_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: picks the byte/halfword addressed by the low address
// bits out of a 32-bit read word and sign- or zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  ld_op_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
  end

  // off_i[0] is ignored for halfwords: misaligned accesses never reach MEM.
  assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    result_o = word_i;
    case (ld_op_e'(ld_op_i))
      LD_OP_B:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_OP_BU: result_o = {24'd0, byte_sel};
      LD_OP_H:  result_o = {{16{half_sel[15]}}, half_sel};
      LD_OP_HU: result_o = {16'd0, half_sel};
      default:  result_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction between EX and WB, keeps
// the one-cycle SRAM read response alive across WB stalls, and aligns load data.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W    = mem_stage_pkg::DATA_W,
  parameter int RF_ADDR_W = mem_stage_pkg::RF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allowin,
  input  logic [DATA_W-1:0]    es_pc,
  input  logic [DATA_W-1:0]    es_alu_result,
  input  logic                 es_res_from_mem,
  input  logic [2:0]           es_ld_op,
  input  logic                 es_rf_we,
  input  logic [RF_ADDR_W-1:0] es_rf_waddr,
  input  logic [DATA_W-1:0]    data_sram_rdata,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [DATA_W-1:0]    ms_pc,
  output logic                 ms_rf_we,
  output logic [RF_ADDR_W-1:0] ms_rf_waddr,
  output logic [DATA_W-1:0]    ms_rf_wdata,
  output logic                 ms_fwd_valid
);

  logic              ms_valid_q, ms_valid_d;
  logic              rdata_held_q, rdata_held_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
  ms_payload_t       pl_q, pl_d;

  logic              accept;
  logic [DATA_W-1:0] rdata_eff;
  logic [31:0]       load_data;

  // MEM never needs more than one cycle, so readiness reduces to WB's allowin.
  assign ms_allowin = !ms_valid_q || ws_allowin;
  assign accept     = es_to_ms_valid && ms_allowin;

  always_comb begin
    ms_valid_d   = ms_valid_q;
    rdata_held_d = rdata_held_q;
    rdata_buf_d  = rdata_buf_q;
    pl_d         = pl_q;

    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end

    if (accept) begin
      pl_d.pc           = es_pc;
      pl_d.alu_result   = es_alu_result;
      pl_d.res_from_mem = es_res_from_mem;
      pl_d.ld_op        = es_ld_op;
      pl_d.rf_we        = es_rf_we;
      pl_d.rf_waddr     = es_rf_waddr;
      rdata_held_d      = 1'b0;
    end else if (ms_valid_q && !rdata_held_q && !ws_allowin) begin
      // SRAM output is only trustworthy in the first cycle; snapshot it on stall.
      rdata_buf_d  = data_sram_rdata;
      rdata_held_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      rdata_held_q <= 1'b0;
      rdata_buf_q  <= '0;
      pl_q         <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      rdata_held_q <= rdata_held_d;
      rdata_buf_q  <= rdata_buf_d;
      pl_q         <= pl_d;
    end
  end

  assign rdata_eff = rdata_held_q ? rdata_buf_q : data_sram_rdata;

  load_align u_load_align (
    .word_i   (rdata_eff),
    .off_i    (pl_q.alu_result[1:0]),
    .ld_op_i  (pl_q.ld_op),
    .result_o (load_data)
  );

  assign ms_to_ws_valid = ms_valid_q;
  assign ms_pc          = pl_q.pc;
  assign ms_rf_we       = ms_valid_q && pl_q.rf_we;
  assign ms_rf_waddr    = pl_q.rf_waddr;
  assign ms_rf_wdata    = pl_q.res_from_mem ? load_data : pl_q.alu_result;
  assign ms_fwd_valid   = ms_rf_we;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage with a queue-based scoreboard.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        es_to_ms_valid = 1'b0;
  logic        ms_allowin;
  logic [31:0] es_pc = '0;
  logic [31:0] es_alu_result = '0;
  logic        es_res_from_mem = 1'b0;
  logic [2:0]  es_ld_op = '0;
  logic        es_rf_we = 1'b0;
  logic [4:0]  es_rf_waddr = '0;
  logic [31:0] data_sram_rdata = '0;
  logic        ws_allowin = 1'b0;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        ms_fwd_valid;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_pc           (es_pc),
    .es_alu_result   (es_alu_result),
    .es_res_from_mem (es_res_from_mem),
    .es_ld_op        (es_ld_op),
    .es_rf_we        (es_rf_we),
    .es_rf_waddr     (es_rf_waddr),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_pc           (ms_pc),
    .ms_rf_we        (ms_rf_we),
    .ms_rf_waddr     (ms_rf_waddr),
    .ms_rf_wdata     (ms_rf_wdata),
    .ms_fwd_valid    (ms_fwd_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mdl_valid = 1'b0;
  logic        mdl_valid_nx = 1'b0;
  logic        rd_pending = 1'b0;
  logic [31:0] rd_word = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Load semantics from the ISA description: pick the addressed unit, then extend.
  function automatic logic [31:0] ref_load(logic [31:0] word, logic [31:0] addr, logic [2:0] op);
    int unsigned b;
    int unsigned h;
    int          v;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      3'd1: begin v = (b >= 128) ? int'(b) - 256 : int'(b); return v; end
      3'd3: return b;
      3'd2: begin v = (h >= 32768) ? int'(h) - 65536 : int'(h); return v; end
      3'd4: return h;
      default: return word;
    endcase
  endfunction

  // One cycle of stimulus. The SRAM returns 'word' in the cycle after an accept;
  // every other cycle it shows 'junk'.
  task automatic drv(input logic ev, input logic [31:0] pc, input logic [31:0] addr,
                     input logic rfm, input logic [2:0] op, input logic we,
                     input logic [4:0] wa, input logic [31:0] word,
                     input logic ws, input logic [31:0] junk);
    exp_t e;
    @(posedge clk); #1;
    mdl_valid       = mdl_valid_nx;
    data_sram_rdata = rd_pending ? rd_word : junk;
    rd_pending      = 1'b0;
    es_to_ms_valid  = ev;
    es_pc           = pc;
    es_alu_result   = addr;
    es_res_from_mem = rfm;
    es_ld_op        = op;
    es_rf_we        = we;
    es_rf_waddr     = wa;
    ws_allowin      = ws;
    if (ev && (!mdl_valid || ws)) begin
      e.pc    = pc;
      e.waddr = wa;
      e.we    = we;
      e.wdata = rfm ? ref_load(word, addr, op) : addr;
      sb_q.push_back(e);
      rd_pending = 1'b1;
      rd_word    = word;
    end
    if (!mdl_valid || ws) mdl_valid_nx = ev;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset          = 1'b1;
    es_to_ms_valid = 1'b0;
    ws_allowin     = 1'b0;
    sb_q.delete();
    mdl_valid      = 1'b0;
    mdl_valid_nx   = 1'b0;
    rd_pending     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: compares the held instruction against the scoreboard head every
  // cycle, and retires it when WB accepts.
  always @(negedge clk) begin
    if (!reset) begin
      chk("ms_to_ws_valid", {31'd0, ms_to_ws_valid}, {31'd0, mdl_valid});
      chk("ms_allowin", {31'd0, ms_allowin}, {31'd0, !mdl_valid || ws_allowin});
      if (mdl_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: DUT valid, got empty queue, required an entry");
        end else begin
          chk("ms_pc", ms_pc, sb_q[0].pc);
          chk("ms_rf_waddr", {27'd0, ms_rf_waddr}, {27'd0, sb_q[0].waddr});
          chk("ms_rf_we", {31'd0, ms_rf_we}, {31'd0, sb_q[0].we});
          chk("ms_fwd_valid", {31'd0, ms_fwd_valid}, {31'd0, sb_q[0].we});
          chk("ms_rf_wdata", ms_rf_wdata, sb_q[0].wdata);
          if (ws_allowin) begin
            $display("txn pc=%h waddr=%0d we=%0d wdata=%h", ms_pc, ms_rf_waddr, ms_rf_we, ms_rf_wdata);
            void'(sb_q.pop_front());
          end
        end
      end else begin
        chk("ms_rf_we_idle", {31'd0, ms_rf_we}, 32'd0);
      end
    end
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("rst_rf_we", {31'd0, ms_rf_we}, 32'd0);
    chk("rst_fwd", {31'd0, ms_fwd_valid}, 32'd0);
    chk("rst_allowin", {31'd0, ms_allowin}, 32'd1);
    chk("rst_pc", ms_pc, 32'd0);
    chk("rst_waddr", {27'd0, ms_rf_waddr}, 32'd0);
    chk("rst_wdata", ms_rf_wdata, 32'd0);

    // Non-load followed by back-to-back byte/halfword loads.
    drv(1, 32'h100, 32'h1234_5678, 0, 3'd0, 1, 5'd5, 32'h0, 1, 32'h0);
    drv(1, 32'h104, 32'h0000_1003, 1, 3'd1, 1, 5'd6, 32'h80FF_0000, 1, 32'h0);
    drv(1, 32'h108, 32'h0000_1003, 1, 3'd3, 1, 5'd7, 32'h80FF_0000, 1, 32'h5555_5555);
    drv(1, 32'h10C, 32'h0000_2002, 1, 3'd2, 1, 5'd8, 32'h8001_7FFF, 1, 32'h5555_5555);
    drv(1, 32'h110, 32'h0000_2000, 1, 3'd4, 1, 5'd9, 32'h8001_7FFF, 1, 32'h5555_5555);
    drv(0, 32'h0, 32'h0, 0, 3'd0, 0, 5'd0, 32'h0, 1, 32'h0);

    // ld.w held across a 3-cycle WB stall while SRAM output drops to zero.
    drv(1, 32'h200, 32'h0000_3000, 1, 3'd0, 1, 5'd10, 32'hDEAD_BEEF, 1, 32'h0);
    repeat (3) drv(0, 32'h0, 32'h0, 0, 3'd0, 0, 5'd0, 32'h0, 0, 32'h0);
    drv(0, 32'h0, 32'h0, 0, 3'd0, 0, 5'd0, 32'h0, 1, 32'h0);

    // Two loads: first stalls (buffer fills), then drain-and-accept replaces it.
    drv(1, 32'h300, 32'h0000_4001, 1, 3'd1, 1, 5'd11, 32'h1122_8344, 1, 32'h0);
    drv(1, 32'h304, 32'h0000_4002, 1, 3'd4, 1, 5'd12, 32'hA5C3_0F0F, 0, 32'h0);
    drv(1, 32'h304, 32'h0000_4002, 1, 3'd4, 1, 5'd12, 32'hA5C3_0F0F, 1, 32'h9999_9999);
    drv(0, 32'h0, 32'h0, 0, 3'd0, 0, 5'd0, 32'h0, 0, 32'h7777_7777);
    drv(0, 32'h0, 32'h0, 0, 3'd0, 0, 5'd0, 32'h0, 1, 32'h6666_6666);

    // Reset in the middle of a stall discards the held instruction.
    drv(1, 32'h400, 32'h0000_5000, 1, 3'd0, 1, 5'd13, 32'hCAFE_F00D, 0, 32'h0);
    drv(0, 32'h0, 32'h0, 0, 3'd0, 0, 5'd0, 32'h0, 0, 32'h0);
    do_reset();
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("rst_mid_rf_we", {31'd0, ms_rf_we}, 32'd0);

    for (int i = 0; i < 500; i++) begin
      drv(($urandom_range(0, 9) < 7), $urandom, $urandom, 1'($urandom), 3'($urandom_range(0, 7)),
          1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 9) < 6), $urandom);
    end

    repeat (4) drv(0, 32'h0, 32'h0, 0, 3'd0, 0, 5'd0, 32'h0, 1, 32'h0);
    @(negedge clk);
    chk("drain_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch pipeline. It sits on the receiving side of the EX→MEM valid/allowin handshake and consumes the data-SRAM read response for loads that EX issued one cycle earlier. It holds one instruction, selects and extends load data by access size and byte offset, and presents the write-back payload to WB. It also drives a forwarding/hazard bundle back to ID.

## Interface
Parameters:
- DATA_W, 32, data and address width (fixed at 32; parameterised for readability only)
- RF_ADDR_W, 5, register-file address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- es_to_ms_valid  in  1  EX holds a valid instruction for MEM
- ms_allowin  out  1  MEM can accept an instruction this cycle
- es_pc  in  32  PC of the offered instruction
- es_alu_result  in  32  ALU result; the memory address for loads/stores
- es_res_from_mem  in  1  instruction is a load
- es_ld_op  in  3  load type: 000 ld.w, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu; other codes are treated as ld.w
- es_rf_we  in  1  instruction writes the register file
- es_rf_waddr  in  5  destination register
- data_sram_rdata  in  32  SRAM read data, valid in the first cycle MEM holds the load
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  MEM offers an instruction to WB
- ms_pc  out  32  PC of the held instruction
- ms_rf_we  out  1  ms_valid && latched rf_we
- ms_rf_waddr  out  5  destination register
- ms_rf_wdata  out  32  final write-back value
- ms_fwd_valid  out  1  equals ms_rf_we; ID uses it for bypass/hazard decisions

## Operation
- ms_ready_go is constant 1.
- ms_allowin = !ms_valid || ws_allowin.
- ms_to_ws_valid = ms_valid.
- Accept happens when es_to_ms_valid && ms_allowin. On accept, latch pc, alu_result, res_from_mem, ld_op, rf_we and rf_waddr. When ms_allowin is high, ms_valid loads es_to_ms_valid.
- Read-data hold:
  - The SRAM output is only guaranteed in the first cycle after the request.
  - Flag rdata_held is cleared on accept.
  - In any cycle with ms_valid && !rdata_held && !ws_allowin, data_sram_rdata is captured into rdata_buf and rdata_held is set.
  - The effective read word is rdata_buf when rdata_held, otherwise data_sram_rdata.
- Load extraction, with off = alu_result[1:0]:
  - B/BU: byte at bits off*8+7..off*8; sign-extended for B, zero-extended for BU.
  - H/HU: halfword selected by alu_result[1]; alu_result[0] is ignored because alignment faults are handled upstream. Sign-extended for H, zero-extended for HU.
  - W: the full word.
- ms_rf_wdata = res_from_mem ? extracted load data : alu_result.
- ms_rf_we, ms_rf_waddr and ms_rf_wdata are valid whenever ms_valid; all outputs are combinational from registered state, except the rdata path.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented to WB in cycle N; it leaves at the first edge where ws_allowin is high.
- Back-to-back throughput is 1 per cycle when ws_allowin stays high.
- Stall: while ws_allowin is low, all latched fields and ms_rf_wdata stay stable, even if data_sram_rdata changes from cycle 2 of the stall onward.
- Simultaneous drain and accept, with ms_valid && ws_allowin && es_to_ms_valid: the new instruction replaces the old at the same edge, and rdata_held clears.
- Drain with no new instruction: ms_valid goes to 0 and ms_rf_we goes to 0.
- Reset values:
  - ms_valid = 0, rdata_held = 0, all payload registers = 0.
  - Outputs: ms_to_ws_valid 0, ms_rf_we 0, ms_fwd_valid 0, ms_pc 0, ms_rf_waddr 0, ms_rf_wdata 0.
  - ms_allowin is 1 in the first cycle after reset.
- Reset mid-stall: the held instruction is discarded with no write-back.

## Structure
- The shared pipeline package holds:
  - the LD_OP_* 3-bit encodings, which EX and ID use too
  - the widths (DATA_W, RF_ADDR_W)
- Sub-module load_align is natural: combinational (word, off, ld_op) → 32-bit result. It is reusable when unaligned or atomic loads are added later.

## Test plan
- Reset → ms_to_ws_valid=0, ms_rf_we=0, ms_allowin=1; all outputs 0.
- Non-load: es_alu_result=0x1234_5678, rf_we=1, waddr=5, ws_allowin=1 → next cycle ms_rf_wdata=0x1234_5678, ms_rf_waddr=5, ms_rf_we=1.
- ld.b at addr 0x...03, rdata=0x80FF_0000 → wdata 0xFFFF_FF80. The same word with ld.bu → 0x0000_0080.
- ld.h at addr 0x...02, rdata=0x8001_7FFF → 0xFFFF_8001. ld.hu at 0x...00 → 0x0000_7FFF.
- ld.w, rdata=0xDEAD_BEEF, ws_allowin low 3 cycles, rdata changed to 0 from cycle 2 → ms_rf_wdata holds 0xDEAD_BEEF throughout; the instruction is released on the first high ws_allowin.
- Simultaneous drain and accept of two loads back-to-back with differing rdata → each write-back carries its own data; rdata_held never leaks between them.
